ee_por_trim_loader: RTL and testbench

Power-on trim loader that sits directly downstream of the EEPROM ECC control stage and consumes its ECC-corrected power-on read data (`por_ee_data_e2l`). After reset release it sequences reads of a fixed block of EEPROM words, retries words flagged uncorrectable, and latches each good word into a trim register bank. It then signals completion to the analog/trim consumers. A reload request re-runs the sequence without a reset.

---
 rtl/ee_por_trim_loader.sv | 158 +++++++++++++++
 tb/tb_ee_por_trim_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee_por_trim_loader.sv
// ee_por_trim_loader
//   Power-on trim loader. After reset release it reads a fixed block of
//   WORD_NUM EEPROM words (BASE_ADDR .. BASE_ADDR+WORD_NUM-1, wrapping mod
//   2^ADDR_W) through the ECC control stage. A word flagged uncorrectable is
//   re-read up to RETRY_MAX times. Each good word is latched into the trim
//   bank, and completion is signalled. A reload request in DONE re-runs the
//   sequence without a reset.
//
// Ports
//   clk              block clock
//   rst              asynchronous, active-high reset
//   reload_req       single-cycle request to re-run the load (honoured in DONE only)
//   por_ee_data_e2l  ECC-decoded EEPROM data, valid RD_WAIT cycles after the strobe
//   ecc_dbl_err      uncorrectable-error flag, valid with the data
//   ee_rd_req        single-cycle EEPROM read strobe
//   ee_addr          EEPROM word address, held from strobe through sampling
//   trim_data        trim bank, word k at [32k+31:32k]
//   por_busy         high while a sequence runs (REQ/WAIT/CHECK)
//   por_load_done    high once a sequence has completed
//   por_load_err     sticky: a word failed after all retries
module ee_por_trim_loader #(
    parameter int                WORD_NUM  = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_WAIT   = 3,
    parameter int                RETRY_MAX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reload_req,
    input  logic [31:0]              por_ee_data_e2l,
    input  logic                     ecc_dbl_err,
    output logic                     ee_rd_req,
    output logic [ADDR_W-1:0]        ee_addr,
    output logic [WORD_NUM*32-1:0]   trim_data,
    output logic                     por_busy,
    output logic                     por_load_done,
    output logic                     por_load_err
);

    localparam int IDX_W  = (WORD_NUM > 1)  ? $clog2(WORD_NUM)      : 1;
    localparam int RTY_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int WCNT_W = (RD_WAIT > 1)   ? $clog2(RD_WAIT)       : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DONE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [RTY_W-1:0]  rty, rty_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              wait_last;
    logic              wr_en, err_set, err_clr;

    // Decoded-read capture; only consumed in CHECK, so no reset is needed.
    logic [31:0]       por_data_p1;
    logic              dbl_err_p1;

    assign wait_last = (wcnt == WCNT_W'(RD_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rty_nxt   = rty;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                idx_nxt   = '0;
                rty_nxt   = '0;
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (wait_last) state_nxt = CHECK;
            end
            CHECK: begin
                if (dbl_err_p1 && (rty < RTY_W'(RETRY_MAX))) begin
                    // Re-read the same address; ee_addr is recomputed from the unchanged idx.
                    rty_nxt   = rty + 1'b1;
                    state_nxt = REQ;
                end else begin
                    // Good word, or retries exhausted: either way move on.
                    wr_en   = !dbl_err_p1;
                    err_set = dbl_err_p1;
                    rty_nxt = '0;
                    if (idx == IDX_W'(WORD_NUM - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            DONE: begin
                if (reload_req) begin
                    err_clr   = 1'b1;
                    idx_nxt   = '0;
                    rty_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            rty           <= '0;
            wcnt          <= '0;
            ee_rd_req     <= 1'b0;
            ee_addr       <= BASE_ADDR;
            trim_data     <= '0;
            por_busy      <= 1'b0;
            por_load_done <= 1'b0;
            por_load_err  <= 1'b0;
        end else begin
            idx           <= idx_nxt;
            rty           <= rty_nxt;
            wcnt          <= (state == WAIT && !wait_last) ? wcnt + 1'b1 : '0;
            ee_rd_req     <= (state_nxt == REQ);
            if (state_nxt == REQ) begin
                ee_addr <= BASE_ADDR + ADDR_W'(idx_nxt);
            end
            por_busy      <= (state_nxt inside {REQ, WAIT, CHECK});
            por_load_done <= (state_nxt == DONE);
            if (err_clr) begin
                por_load_err <= 1'b0;
            end else if (err_set) begin
                por_load_err <= 1'b1;
            end
            for (int k = 0; k < WORD_NUM; k++) begin
                if (wr_en && idx == IDX_W'(k)) begin
                    trim_data[k*32 +: 32] <= por_data_p1;
                end
            end
        end
    end

    // Stage p1: sample the decoded read on the edge that ends the last WAIT cycle
    always_ff @(posedge clk) begin
        if (state == WAIT && wait_last) begin
            por_data_p1 <= por_ee_data_e2l;
            dbl_err_p1  <= ecc_dbl_err;
        end
    end

endmodule

// File: tb/tb_ee_por_trim_loader.sv
module tb_ee_por_trim_loader;

    localparam int          WORD_NUM  = 4;
    localparam int          RD_WAIT   = 3;
    localparam int          RETRY_MAX = 1;
    localparam logic [7:0]  BASE      = 8'h00;
    localparam int          MAXL      = 64;

    logic         clk = 1'b0;
    logic         rst, reload_req;
    logic [31:0]  por_ee_data_e2l;
    logic         ecc_dbl_err;
    logic         ee_rd_req;
    logic [7:0]   ee_addr;
    logic [127:0] trim_data;
    logic         por_busy, por_load_done, por_load_err;

    logic         rst_v, reload_v;
    logic [31:0]  data_v;
    logic         err_v;
    logic         req_v;
    logic [7:0]   addr_v;
    logic [127:0] trim_v;
    logic         busy_v, done_v, lerr_v;

    ee_por_trim_loader #(.WORD_NUM(WORD_NUM), .ADDR_W(8), .BASE_ADDR(BASE),
                         .RD_WAIT(RD_WAIT), .RETRY_MAX(RETRY_MAX)) u_dut (
        .clk(clk), .rst(rst), .reload_req(reload_req),
        .por_ee_data_e2l(por_ee_data_e2l), .ecc_dbl_err(ecc_dbl_err),
        .ee_rd_req(ee_rd_req), .ee_addr(ee_addr), .trim_data(trim_data),
        .por_busy(por_busy), .por_load_done(por_load_done), .por_load_err(por_load_err));

    ee_por_trim_loader #(.WORD_NUM(4), .ADDR_W(8), .BASE_ADDR(8'hFE),
                         .RD_WAIT(1), .RETRY_MAX(1)) u_var (
        .clk(clk), .rst(rst_v), .reload_req(reload_v),
        .por_ee_data_e2l(data_v), .ecc_dbl_err(err_v),
        .ee_rd_req(req_v), .ee_addr(addr_v), .trim_data(trim_v),
        .por_busy(busy_v), .por_load_done(done_v), .por_load_err(lerr_v));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int rel, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s rel=%0d got=%0h exp=%0h", nm, rel, act, exp);
        end
    endtask

    // ---------------- behavioural model: expected trace per cycle ----------------
    logic [31:0]  mem [WORD_NUM];
    bit           plan [WORD_NUM][RETRY_MAX+1];   // 1 = read attempt returns dbl error
    bit           e_req  [MAXL];
    logic [7:0]   e_addr [MAXL];
    bit           e_busy [MAXL];
    bit           e_done [MAXL];
    bit           e_lerr [MAXL];
    logic [127:0] e_trim [MAXL];
    int           wstart [WORD_NUM];
    int           seq_len;

    // Each read attempt occupies RD_WAIT+2 cycles starting with its strobe;
    // its outcome becomes visible at the start of the following slot.
    task automatic build_model(input logic [127:0] trim0);
        int t;
        logic [127:0] tr;
        bit er;
        logic [7:0] a;
        t = 0; tr = trim0; er = 0; a = BASE;
        for (int k = 0; k < WORD_NUM; k++) begin
            wstart[k] = t;
            for (int r = 0; r <= RETRY_MAX; r++) begin
                a = BASE + 8'(k);
                for (int j = 0; j < RD_WAIT + 2; j++) begin
                    e_req[t+j] = (j == 0); e_addr[t+j] = a; e_busy[t+j] = 1;
                    e_done[t+j] = 0; e_trim[t+j] = tr; e_lerr[t+j] = er;
                end
                t += RD_WAIT + 2;
                if (!plan[k][r]) begin
                    tr[32*k +: 32] = mem[k];
                    break;
                end else if (r == RETRY_MAX) begin
                    er = 1;
                end
            end
        end
        seq_len = t;
        for (int j = t; j < MAXL; j++) begin
            e_req[j] = 0; e_addr[j] = a; e_busy[j] = 0;
            e_done[j] = 1; e_trim[j] = tr; e_lerr[j] = er;
        end
    endtask

    // ---------------- EEPROM/ECC stimulus for main DUT ----------------
    int att [WORD_NUM];
    int rd_cnt = 100;
    int cur_w  = 0;
    int cur_a  = 0;

    always @(negedge clk) begin
        logic [7:0] woff;
        if (ee_rd_req) begin
            rd_cnt = 0;
            woff   = ee_addr - BASE;
            cur_w  = int'(woff);
            if (cur_w < WORD_NUM) begin
                cur_a = att[cur_w];
                att[cur_w]++;
            end
        end else if (rd_cnt < 1000) begin
            rd_cnt++;
        end
        // Valid data only in the sampling cycle; noise everywhere else.
        if (rd_cnt == RD_WAIT && cur_w < WORD_NUM) begin
            por_ee_data_e2l = mem[cur_w];
            ecc_dbl_err     = (cur_a <= RETRY_MAX) ? plan[cur_w][cur_a] : 1'b0;
        end else begin
            por_ee_data_e2l = $urandom;
            ecc_dbl_err     = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- variant EEPROM (RD_WAIT=1, no errors) ----------------
    logic [31:0] mem_v [4];
    bit          v_pend = 0;
    int          v_word = 0;

    always @(negedge clk) begin
        logic [7:0] voff;
        if (v_pend && v_word < 4) data_v = mem_v[v_word];
        else                      data_v = $urandom;
        err_v  = 1'b0;
        v_pend = 0;
        if (req_v) begin
            v_pend = 1;
            voff   = addr_v - 8'hFE;
            v_word = int'(voff);
        end
    end

    // ---------------- compare process ----------------
    bit chk_en    = 0;
    int seq_start = 0;
    bit done_seen = 0;
    int done_rel  = -1;
    int strobe_cnt = 0;

    always @(posedge clk) begin
        int rel;
        #1;
        if (chk_en) begin
            rel = cyc - seq_start;
            if (rel >= 0 && rel < MAXL) begin
                chk("ee_rd_req",     rel, ee_rd_req,     e_req[rel]);
                chk("ee_addr",       rel, ee_addr,       e_addr[rel]);
                chk("por_busy",      rel, por_busy,      e_busy[rel]);
                chk("por_load_done", rel, por_load_done, e_done[rel]);
                chk("por_load_err",  rel, por_load_err,  e_lerr[rel]);
                chk("trim_data",     rel, trim_data,     e_trim[rel]);
                if (ee_rd_req) strobe_cnt++;
                if (por_load_done && !done_seen) begin
                    done_seen = 1;
                    done_rel  = rel;
                end
            end
        end
    end

    // ---------------- sequencing helpers (called at a negedge) ----------------
    task automatic start_common(input logic [127:0] trim0);
        for (int k = 0; k < WORD_NUM; k++) att[k] = 0;
        build_model(trim0);
        seq_start  = cyc + 1;
        done_seen  = 0;
        done_rel   = -1;
        strobe_cnt = 0;
        chk_en     = 1;
    endtask

    task automatic reset_start();
        rst    = 1;
        chk_en = 0;
        repeat (2) @(negedge clk);
        start_common('0);
        rst = 0;
    endtask

    task automatic reload_start();
        logic [127:0] prev;
        prev = e_trim[MAXL-1];
        start_common(prev);
        reload_req = 1;
        @(negedge clk);
        reload_req = 0;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - seq_start < r) @(negedge clk);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < WORD_NUM; k++)
            for (int r = 0; r <= RETRY_MAX; r++) plan[k][r] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; reload_req = 0; rst_v = 1; reload_v = 0;
        por_ee_data_e2l = '0; ecc_dbl_err = 0;
        for (int k = 0; k < WORD_NUM; k++) att[k] = 0;
        clear_plan();
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        repeat (3) @(negedge clk);

        chk("rst_req",   -1, ee_rd_req,     0);
        chk("rst_addr",  -1, ee_addr,       8'h00);
        chk("rst_trim",  -1, trim_data,     0);
        chk("rst_busy",  -1, por_busy,      0);
        chk("rst_done",  -1, por_load_done, 0);
        chk("rst_err",   -1, por_load_err,  0);
        chk("rst_addr_v",-1, addr_v,        8'hFE);

        // clean load, with an ignored reload pulse during WAIT of word 0
        start_common('0);
        rst = 0;
        wait_rel(2);
        reload_req = 1;
        @(negedge clk);
        reload_req = 0;
        wait_rel(seq_len + 2);
        chk("s1_done_cycle", -1, done_rel, 20);
        chk("s1_trim", -1, trim_data, 128'h44444444_33333333_22222222_11111111);
        chk("s1_err", -1, por_load_err, 0);
        chk("s1_strobes", -1, strobe_cnt, 4);

        // single error on first read of word 1
        plan[1][0] = 1;
        reset_start();
        wait_rel(seq_len + 2);
        chk("s2_done_cycle", -1, done_rel, 25);
        chk("s2_word1", -1, trim_data[63:32], 32'h22222222);
        chk("s2_err", -1, por_load_err, 0);
        chk("s2_strobes", -1, strobe_cnt, 5);

        // word 2 fails both reads
        clear_plan();
        plan[2][0] = 1; plan[2][1] = 1;
        reset_start();
        wait_rel(seq_len + 2);
        chk("s3_done_cycle", -1, done_rel, 25);
        chk("s3_err", -1, por_load_err, 1);
        chk("s3_trim", -1, trim_data, 128'h44444444_00000000_22222222_11111111);

        // reload in DONE after the error run
        clear_plan();
        mem[0] = 32'hAAAA0000; mem[1] = 32'hBBBB1111;
        mem[2] = 32'hCCCC2222; mem[3] = 32'hDDDD3333;
        reload_start();
        chk("s4_req", 0, ee_rd_req, 1);
        chk("s4_addr", 0, ee_addr, 8'h00);
        chk("s4_done_clr", 0, por_load_done, 0);
        chk("s4_err_clr", 0, por_load_err, 0);
        chk("s4_old_trim", 0, trim_data, 128'h44444444_00000000_22222222_11111111);
        wait_rel(seq_len + 2);
        chk("s4_trim", -1, trim_data, 128'hDDDD3333_CCCC2222_BBBB1111_AAAA0000);

        // reset during WAIT of word 2
        reload_start();
        wait_rel(wstart[2] + 2);
        rst    = 1;
        chk_en = 0;
        #1;
        chk("s5_trim", -1, trim_data, 0);
        chk("s5_req", -1, ee_rd_req, 0);
        chk("s5_busy", -1, por_busy, 0);
        chk("s5_done", -1, por_load_done, 0);
        chk("s5_addr", -1, ee_addr, BASE);
        repeat (2) @(negedge clk);
        start_common('0);
        rst = 0;
        @(negedge clk);
        chk("s5_restart_req", 0, ee_rd_req, 1);
        chk("s5_restart_addr", 0, ee_addr, BASE);
        wait_rel(seq_len + 2);

        // randomized runs
        for (int it = 0; it < 10; it++) begin
            int r;
            for (int k = 0; k < WORD_NUM; k++) begin
                mem[k] = $urandom;
                for (int a = 0; a <= RETRY_MAX; a++) plan[k][a] = ($urandom_range(0, 2) == 0);
            end
            if (it % 4 == 3) reset_start();
            else             reload_start();
            r = $urandom_range(1, seq_len - 1);
            wait_rel(r);
            reload_req = 1;
            @(negedge clk);
            reload_req = 0;
            wait_rel(seq_len + 2);
        end
        chk_en = 0;

        // variant: RD_WAIT=1, BASE_ADDR=FE, address wrap
        for (int k = 0; k < 4; k++) mem_v[k] = $urandom;
        @(negedge clk);
        rst_v = 0;
        begin
            int vstart;
            logic [7:0] ea;
            vstart = cyc + 1;
            for (int i = 0; i < 16; i++) begin
                int r;
                @(negedge clk);
                r = cyc - vstart;
                chk("v_req", r, req_v, (r < 12 && r % 3 == 0));
                if (r < 12 && r % 3 == 0) begin
                    ea = 8'hFE + 8'(r / 3);
                    chk("v_addr", r, addr_v, ea);
                end
                chk("v_done", r, done_v, (r >= 12));
                chk("v_busy", r, busy_v, (r < 12));
            end
        end
        chk("v_trim", -1, trim_v, {mem_v[3], mem_v[2], mem_v[1], mem_v[0]});
        chk("v_err", -1, lerr_v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
